param_bus_fifo: RTL and testbench
=================================

# param_bus_fifo

Parametrised ready/valid FIFO for carrying simple-bus payloads between two interface instances. Data width and depth are elaboration parameters, and `DATA_W` is normally bound from `$bits()` of an upstream interface parameter. Elaboration-time `$error` checks reject illegal parameter combinations. It sits between a producer and a consumer bus and adds buffering, backpressure and an occupancy count.

## Interface
- `DATA_W`, 7: payload width; legal range 1..64; bound from `$bits(<intf>.<param>)` at instantiation.
- `DEPTH`, 4: entry count; power of two, 2..256.
- `CNT_W`, `$clog2(DEPTH+1)`: occupancy width; localparam, not overridable.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  synchronous reset, active-low.
- `in_valid`  input  1  producer offers `in_data`.
- `in_ready`  output  1  FIFO accepts this cycle.
- `in_data`  input  DATA_W  write payload.
- `out_valid`  output  1  `out_data` holds the head entry.
- `out_ready`  input  1  consumer takes the head.
- `out_data`  output  DATA_W  head payload.
- `count`  output  CNT_W  entries stored, 0..DEPTH.

## Operation
- Storage: DEPTH-entry register array, write pointer `wp` and read pointer `rp`. Each pointer is `$clog2(DEPTH)` bits and wraps modulo DEPTH without an explicit compare.
- Full is `count==DEPTH`; empty is `count==0`.
- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. It is never gated by `out_ready`, so there is no combinational path from the consumer to the producer.
- `out_valid = (count != 0)`. In the base build, `out_data = mem[rp]`.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged. This is legal at any 0 < count < DEPTH.
- Push only: `count+1`. Pop only: `count-1`.
- Stalled output: `out_data` is stable while `out_valid && !out_ready`.
- Elaboration checks:
  - `DEPTH` not a power of two, or outside range -> `$error("Bad DEPTH")`.
  - `DATA_W` out of range -> `$error("Bad DATA_W")`.
  - Both checks use generate-if at module scope.
- Reset (`rst_n` low at a rising edge):
  - `wp=0`, `rp=0`, `count=0`.
  - Memory contents are not reset.
  - Takes priority over a simultaneous push or pop. Mid-stream data is discarded.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `count=0`, `out_data` X/don't-care.
- Latency, base build: a push at edge N gives `out_valid=1` after edge N, so the data is poppable in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- `count` updates on the edge following the handshake.
- Full boundary: at count==DEPTH, `in_ready=0` even if `out_ready=1`. After a pop, `in_ready` returns the next cycle.
- Empty boundary: at count==0, `out_valid=0` and `out_ready` is ignored.

## Configuration
- Macro: `PARAM_BUS_FIFO_BYPASS_EN`.
- Defined:
  - When count==0 and `in_valid`, `out_valid=1` and `out_data=in_data` combinationally.
  - If `out_ready` is also high, the word passes through. It is not stored, pointers do not move and `count` stays 0.
  - If `out_ready` is low, the word is stored normally.
  - `in_ready` is unchanged, so count==0 still gives `in_ready=1`.
  - Latency is 0 cycles when empty.
- Undefined: 1-cycle minimum latency, and no combinational path from any input to `out_valid`/`out_data`.

## Test plan
- Reset: hold `rst_n=0` 2 cycles with `in_valid=1` -> `count=0`, `out_valid=0`, `in_ready=1`; no write occurs.
- Fill/drain, `DEPTH=4`, `DATA_W=$bits` of a 7-bit interface parameter:
  - Push 0x11,0x22,0x33,0x44 with `out_ready=0` -> `count=4`, `in_ready=0`.
  - Fifth push with 0x55 is refused.
  - Drain -> 0x11,0x22,0x33,0x44 in order, then `count=0`.
- Full with simultaneous offer: at count=4 assert `in_valid=1` and `out_ready=1` together -> one pop, no push, `count=3`; next cycle the push is accepted.
- Wrap-around: stream 10 words with both sides always ready -> output order intact, `count` steady at 1 (base) or 0 (bypass); pointers wrap twice.
- Reset mid-stream: at count=3 pulse `rst_n=0` for one cycle -> `count=0`, `out_valid=0`; the next push of 0x7F is the first word read.
- Elaboration: instantiate with `DEPTH=6` -> build fails with "Bad DEPTH".
- Bypass (macro defined), empty: `in_valid=1`, `out_ready=1`, `in_data=0x2A` -> same cycle `out_valid=1`, `out_data=0x2A`, `count` remains 0.

Source files
------------

// File: rtl/param_bus_fifo.sv
// ----------------------------------------------------------------------------
// param_bus_fifo
//
// Parametrised ready/valid FIFO that buffers simple-bus payloads between a
// producer and a consumer. It provides backpressure and an occupancy count.
// DATA_W is normally bound from $bits() of an upstream interface parameter.
//
// Optional feature macro: PARAM_BUS_FIFO_BYPASS_EN
//   When defined, an empty FIFO forwards in_data straight to out_data in the
//   same cycle. If the consumer takes the word, it is never stored.
//   When undefined, the minimum latency is one cycle, and no combinational
//   path runs from any input to out_valid/out_data.
//
// Parameters:
//   DATA_W  payload width, 1..64
//   DEPTH   entry count, power of two, 2..256
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   in_valid   in   producer offers in_data
//   in_ready   out  FIFO accepts this cycle (never depends on out_ready)
//   in_data    in   write payload
//   out_valid  out  out_data holds the head entry
//   out_ready  in   consumer takes the head
//   out_data   out  head payload
//   count      out  entries stored, 0..DEPTH
// ----------------------------------------------------------------------------
module param_bus_fifo #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Elaboration-time parameter legality checks
    if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("Bad DEPTH");
    end
    if ((DATA_W < 1) || (DATA_W > 64)) begin : g_bad_data_w
        $error("Bad DATA_W");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_bypass;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign count    = r_count;

`ifdef PARAM_BUS_FIFO_BYPASS_EN
    // An empty FIFO presents the incoming word directly; a taken word is not stored.
    assign w_bypass  = w_empty && in_valid && out_ready;
    assign out_valid = !w_empty || in_valid;
    assign out_data  = w_empty ? in_data : r_mem[r_rp];
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rp];
`endif

    assign w_push = in_valid && in_ready && !w_bypass;
    assign w_pop  = out_valid && out_ready && !w_bypass;

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_param_bus_fifo.sv
// ----------------------------------------------------------------------------
// tb_param_bus_fifo
//
// Self-checking bench for param_bus_fifo (DEPTH=4, 7-bit payload). It runs
// three phases:
//   - a table of directed vectors (reset, fill, full refusal, full with a
//     simultaneous offer, drain)
//   - hand-written sequences (wrap-around streaming, reset mid-stream, and
//     bypass when enabled)
//   - randomized traffic checked against a queue-based reference model
// ----------------------------------------------------------------------------
module tb_param_bus_fifo;

    typedef logic [6:0] payload_t;
    localparam int DW    = $bits(payload_t);
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    param_bus_fifo #(
        .DATA_W ($bits(payload_t)),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the FIFO contents, head first
    payload_t q[$];

    typedef struct {
        logic     rst_n;
        logic     iv;
        payload_t d;
        logic     ordy;
        logic     chk;
        logic     e_ir;
        logic     e_ov;
        int       e_cnt;
        payload_t e_d;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic r, input logic iv, input payload_t d,
                                input logic ordy, input logic chk, input logic e_ir,
                                input logic e_ov, input int e_cnt, input payload_t e_d);
        vec_t v;
        v.rst_n = r;   v.iv = iv;     v.d = d;       v.ordy = ordy;
        v.chk = chk;   v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt;
        v.e_d = e_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, then let combinational outputs settle
    task automatic apply(input logic r, input logic iv, input payload_t d, input logic ordy);
        @(negedge clk);
        rst_n     = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    // Compare the outputs against what the model predicts for the current inputs
    task automatic model_check(input string tag);
        logic     e_ir;
        logic     e_ov;
        payload_t e_d;
        e_ir = (q.size() != DEPTH);
        e_ov = (q.size() != 0);
        e_d  = (q.size() != 0) ? q[0] : in_data;
`ifdef PARAM_BUS_FIFO_BYPASS_EN
        if (q.size() == 0 && in_valid) e_ov = 1'b1;
`endif
        check({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, ".count"},     32'(count),     32'(q.size()));
        if (e_ov) check({tag, ".out_data"}, 32'(out_data), 32'(e_d));
    endtask

    // Advance one clock edge and update the model from the held inputs
    task automatic model_commit();
        int  sz;
        logic bypass;
        @(posedge clk);
        sz     = q.size();
        bypass = 1'b0;
`ifdef PARAM_BUS_FIFO_BYPASS_EN
        bypass = (sz == 0) && in_valid && out_ready;
`endif
        if (!rst_n) begin
            q.delete();
        end else if (!bypass) begin
            if (sz != 0 && out_ready) void'(q.pop_front());
            if (in_valid && sz != DEPTH) q.push_back(in_data);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Directed table: reset with an offer present, fill, refusal at full,
        // full with simultaneous offer, then drain
        vecs[0]  = mk(0, 1, 7'h55, 0, 0, 1, 0, 0, 7'h00);
        vecs[1]  = mk(0, 1, 7'h66, 0, 0, 1, 0, 0, 7'h00);
        vecs[2]  = mk(1, 0, 7'h00, 0, 1, 1, 0, 0, 7'h00);
        vecs[3]  = mk(1, 1, 7'h11, 0, 1, 1, 0, 0, 7'h00);
        vecs[4]  = mk(1, 1, 7'h22, 0, 1, 1, 1, 1, 7'h11);
        vecs[5]  = mk(1, 1, 7'h33, 0, 1, 1, 1, 2, 7'h11);
        vecs[6]  = mk(1, 1, 7'h44, 0, 1, 1, 1, 3, 7'h11);
        vecs[7]  = mk(1, 1, 7'h55, 0, 1, 0, 1, 4, 7'h11);
        vecs[8]  = mk(1, 1, 7'h55, 1, 1, 0, 1, 4, 7'h11);
        vecs[9]  = mk(1, 1, 7'h55, 1, 1, 1, 1, 3, 7'h22);
        vecs[10] = mk(1, 0, 7'h00, 1, 1, 1, 1, 3, 7'h33);
        vecs[11] = mk(1, 0, 7'h00, 1, 1, 1, 1, 2, 7'h44);
        vecs[12] = mk(1, 0, 7'h00, 1, 1, 1, 1, 1, 7'h55);
        vecs[13] = mk(1, 0, 7'h00, 0, 1, 1, 0, 0, 7'h00);

        for (int i = 0; i < 14; i++) begin
            logic     e_ov;
            payload_t e_d;
            apply(vecs[i].rst_n, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            e_ov = vecs[i].e_ov;
            e_d  = vecs[i].e_d;
`ifdef PARAM_BUS_FIFO_BYPASS_EN
            if (vecs[i].e_cnt == 0 && vecs[i].iv) begin
                e_ov = 1'b1;
                e_d  = vecs[i].d;
            end
`endif
            if (vecs[i].chk) begin
                check($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
                check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(e_ov));
                check($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].e_cnt));
                if (e_ov) check($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(e_d));
            end
            model_commit();
        end

        // Wrap-around: 10 words, both sides always ready
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, payload_t'(7'h60 + i), 1);
            model_check($sformatf("wrap%0d", i));
`ifdef PARAM_BUS_FIFO_BYPASS_EN
            check($sformatf("wrap%0d.steady_count", i), 32'(count), 32'd0);
`else
            check($sformatf("wrap%0d.steady_count", i), 32'(count), (i == 0) ? 32'd0 : 32'd1);
`endif
            model_commit();
        end
        // Drain whatever the stream left behind
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 7'h00, 1);
            model_check($sformatf("wrap_drain%0d", i));
            model_commit();
        end

        // Reset mid-stream at count=3
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, payload_t'(7'h01 + i), 0);
            model_commit();
        end
        apply(1, 0, 7'h00, 0);
        check("midrst.count_before", 32'(count), 32'd3);
        apply(0, 1, 7'h0F, 0);
        model_commit();
        apply(1, 0, 7'h00, 0);
        check("midrst.count", 32'(count), 32'd0);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        model_commit();
        apply(1, 1, 7'h7F, 0);
        model_commit();
        apply(1, 0, 7'h00, 1);
        check("midrst.first_word", 32'(out_data), 32'h7F);
        check("midrst.first_valid", 32'(out_valid), 32'd1);
        model_commit();

`ifdef PARAM_BUS_FIFO_BYPASS_EN
        // Bypass when empty: same-cycle pass-through, nothing stored
        apply(1, 1, 7'h2A, 1);
        check("bypass.out_valid", 32'(out_valid), 32'd1);
        check("bypass.out_data", 32'(out_data), 32'h2A);
        check("bypass.count", 32'(count), 32'd0);
        model_commit();
        apply(1, 0, 7'h00, 1);
        check("bypass.count_after", 32'(count), 32'd0);
        check("bypass.valid_after", 32'(out_valid), 32'd0);
        model_commit();
`endif

        // Randomized traffic against the reference model, with varied consumer bias
        for (int blk = 0; blk < 10; blk++) begin
            int bias;
            bias = blk % 4;
            for (int i = 0; i < 200; i++) begin
                logic r;
                logic iv;
                logic ordy;
                r    = ($urandom_range(63) != 0);
                iv   = ($urandom_range(3) != 0);
                ordy = ($urandom_range(3) < bias);
                apply(r, iv, payload_t'($urandom), ordy);
                model_check($sformatf("rnd%0d_%0d", blk, i));
                model_commit();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
